// File: rtl/alu_pipe_pkg.sv
// Shared opcode encodings and pipeline payload types for the pipelined ALU.
package alu_pipe_pkg;

    localparam int unsigned OPCODE_W = 3;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_ADD  = 3'b000;
    localparam opcode_t OP_SUB  = 3'b001;
    localparam opcode_t OP_AND  = 3'b010;
    localparam opcode_t OP_OR   = 3'b011;
    localparam opcode_t OP_XOR  = 3'b100;
    localparam opcode_t OP_NAND = 3'b101;
    localparam opcode_t OP_NOR  = 3'b110;
    localparam opcode_t OP_NOT  = 3'b111;

    // Control fields captured in S1 alongside the operands.
    typedef struct packed {
        opcode_t opcode;
        logic    sel_src;
        logic    acc_clr;
    } s1_ctrl_t;

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU: eight arithmetic/logic ops plus carry/borrow.
// Optional macro ALU_SAT_EN: ADD clamps to all-ones on carry, SUB clamps to 0
// on borrow; carry still reports the raw carry/borrow.
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  opcode_t          opcode,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // Extended-width add and subtract; the top bit is carry / borrow.
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    // Operation select; logic ops never produce a carry.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (opcode)
            OP_ADD: begin
                carry = w_sum[WIDTH];
`ifdef ALU_SAT_EN
                result = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
`else
                result = w_sum[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                carry = w_diff[WIDTH];
`ifdef ALU_SAT_EN
                result = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
`else
                result = w_diff[WIDTH-1:0];
`endif
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            default: result = ~a;  // OP_NOT
        endcase
    end

endmodule

// File: rtl/alu_pipe_acc.sv
// Two-stage pipelined ALU with valid/ready handshake and a chaining accumulator.
// S1 captures the operand beat; S2 is the output register and updates the
// accumulator. Optional macro ALU_SAT_EN enables saturating ADD/SUB in alu_core.
module alu_pipe_acc
    import alu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  opcode_t          opcode,
    input  logic             sel_src,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             zero
);

    // S1 stage
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_in1;
    logic [WIDTH-1:0] r_s1_in2;
    s1_ctrl_t         r_s1_ctrl;

    // S2 stage and accumulator
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_carry;
    logic             r_zero;
    logic [WIDTH-1:0] r_acc;

    logic             w_s2_load;
    logic             w_in_ready;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;

    // Pipeline advance: S2 takes S1 whenever its current result is gone or leaving.
    assign w_s2_load  = r_s1_valid && (!r_out_valid || out_ready);
    assign w_in_ready = !rst && (!r_s1_valid || w_s2_load);

    // The accumulator is read when S1 computes, so a chained beat sees the
    // result loaded into S2 on the previous edge without any bubble.
    assign w_op_a = r_s1_ctrl.sel_src ? r_acc : r_s1_in1;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .a      (w_op_a),
        .b      (r_s1_in2),
        .opcode (r_s1_ctrl.opcode),
        .result (w_result),
        .carry  (w_carry)
    );

    // S1 register: capture a beat whenever the stage can accept one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_in1   <= '0;
            r_s1_in2   <= '0;
            r_s1_ctrl  <= '0;
        end else if (w_in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_in1  <= in1;
                r_s1_in2  <= in2;
                r_s1_ctrl <= '{opcode: opcode, sel_src: sel_src, acc_clr: acc_clr};
            end
        end
    end

    // S2 register and accumulator: load on advance, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_acc       <= '0;
        end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
            r_out       <= w_result;
            r_carry     <= w_carry;
            r_zero      <= (w_result == '0);
            r_acc       <= r_s1_ctrl.acc_clr ? '0 : w_result;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign carry_out = r_carry;
    assign zero      = r_zero;

endmodule

// File: tb/tb_alu_pipe_acc.sv
// Directed self-checking bench for alu_pipe_acc (WIDTH=8).
module tb_alu_pipe_acc;

    localparam int unsigned W = 8;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;

`ifdef ALU_SAT_EN
    localparam logic [W-1:0] EXP_ADD_OVF = 8'd255;
    localparam logic [W-1:0] EXP_SUB_BRW = 8'd0;
    localparam logic         EXP_SUB_BRW_Z = 1'b1;
`else
    localparam logic [W-1:0] EXP_ADD_OVF = 8'd44;
    localparam logic [W-1:0] EXP_SUB_BRW = 8'd254;
    localparam logic         EXP_SUB_BRW_Z = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [2:0]   opcode;
    logic         sel_src;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         carry_out;
    logic         zero;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_pipe_acc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .opcode    (opcode),
        .sel_src   (sel_src),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .carry_out (carry_out),
        .zero      (zero)
    );

    // Present a beat and return 1ns after the edge that accepts it.
    task automatic beat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sel, input logic clr);
        int waited;
        in_valid = 1'b1; opcode = op; in1 = a; in2 = b; sel_src = sel; acc_clr = clr;
        #1;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #2;
            waited++;
        end
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic set_bp_beat(input int i);
        if (i < 4) begin
            in_valid = 1'b1; opcode = ADD; in1 = 8'(10 * i + 1); in2 = 8'd1;
            sel_src = 1'b0; acc_clr = 1'b0;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in1 = '0; in2 = '0; opcode = ADD; sel_src = 1'b0; acc_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out !== 8'd0) $display("FAIL rst_out: got %0d want 0", out); else n_pass++;
        n_checks++; if (carry_out !== 1'b0) $display("FAIL rst_carry: got %b want 0", carry_out); else n_pass++;
        n_checks++; if (zero !== 1'b0) $display("FAIL rst_zero: got %b want 0", zero); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        beat(ADD, 8'd200, 8'd100, 1'b0, 1'b0);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL add_early_valid: got %b want 0", out_valid); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL add_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out !== EXP_ADD_OVF) $display("FAIL add_out: got %0d want %0d", out, EXP_ADD_OVF); else n_pass++;
        n_checks++; if (carry_out !== 1'b1) $display("FAIL add_carry: got %b want 1", carry_out); else n_pass++;
        n_checks++; if (zero !== 1'b0) $display("FAIL add_zero: got %b want 0", zero); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL add_drain: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_sub();
        out_ready = 1'b1;
        beat(SUB, 8'd5, 8'd7, 1'b0, 1'b0);
        beat(SUB, 8'd7, 8'd7, 1'b0, 1'b0);
        in_valid = 1'b0;
        n_checks++; if (out !== EXP_SUB_BRW) $display("FAIL sub57_out: got %0d want %0d", out, EXP_SUB_BRW); else n_pass++;
        n_checks++; if (carry_out !== 1'b1) $display("FAIL sub57_borrow: got %b want 1", carry_out); else n_pass++;
        n_checks++; if (zero !== EXP_SUB_BRW_Z) $display("FAIL sub57_zero: got %b want %b", zero, EXP_SUB_BRW_Z); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL sub77_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out !== 8'd0) $display("FAIL sub77_out: got %0d want 0", out); else n_pass++;
        n_checks++; if (zero !== 1'b1) $display("FAIL sub77_zero: got %b want 1", zero); else n_pass++;
        n_checks++; if (carry_out !== 1'b0) $display("FAIL sub77_borrow: got %b want 0", carry_out); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        beat(ADD, 8'd10, 8'd3, 1'b0, 1'b1);
        beat(ADD, 8'hEE, 8'd3, 1'b1, 1'b0);
        n_checks++; if (out !== 8'd13) $display("FAIL chain1_out: got %0d want 13", out); else n_pass++;
        beat(ADD, 8'h55, 8'd4, 1'b1, 1'b0);
        in_valid = 1'b0;
        n_checks++; if (out !== 8'd3) $display("FAIL chain2_out: got %0d want 3", out); else n_pass++;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL chain2_valid: got %b want 1", out_valid); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (out !== 8'd7) $display("FAIL chain3_out: got %0d want 7", out); else n_pass++;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL chain3_valid: got %b want 1", out_valid); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_logic();
        logic [W-1:0] exp_v [6];
        exp_v[0] = 8'h05; exp_v[1] = 8'hAF; exp_v[2] = 8'hAA;
        exp_v[3] = 8'hFA; exp_v[4] = 8'h50; exp_v[5] = 8'h5A;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            beat(3'(i + 2), 8'hA5, 8'h0F, 1'b0, 1'b0);
            if (i > 0) begin
                n_checks++;
                if (out !== exp_v[i-1] || carry_out !== 1'b0)
                    $display("FAIL logic_op%0d: got out=%h carry=%b want out=%h carry=0", i + 1, out, carry_out, exp_v[i-1]);
                else n_pass++;
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (out !== exp_v[5] || carry_out !== 1'b0)
            $display("FAIL logic_op7: got out=%h carry=%b want out=%h carry=0", out, carry_out, exp_v[5]);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] recv [4];
        int nsent, nrecv, accepts;
        logic fire_in, fire_out;
        out_ready = 1'b0;
        nsent = 0; nrecv = 0; accepts = 0;
        set_bp_beat(0);
        for (int c = 0; c < 5; c++) begin
            #1;
            fire_in = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire_in) begin accepts++; nsent++; set_bp_beat(nsent); end
            if (c >= 1) begin
                n_checks++;
                if (out_valid !== 1'b1 || out !== 8'd2)
                    $display("FAIL bp_hold_c%0d: got valid=%b out=%0d want valid=1 out=2", c, out_valid, out);
                else n_pass++;
            end
        end
        #1;
        n_checks++; if (accepts != 2) $display("FAIL bp_accepts: got %0d want 2", accepts); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready); else n_pass++;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && nrecv < 4; c++) begin
            #1;
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin recv[nrecv] = out; nrecv++; end
            @(posedge clk); #1;
            if (fire_in) begin nsent++; set_bp_beat(nsent); end
        end
        n_checks++; if (nrecv != 4) $display("FAIL bp_count: got %0d want 4", nrecv); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (recv[i] !== 8'(10 * i + 2)) $display("FAIL bp_order%0d: got %0d want %0d", i, recv[i], 10 * i + 2);
            else n_pass++;
        end
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_no_dup: got valid=%b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        beat(ADD, 8'd50, 8'd50, 1'b0, 1'b0);
        beat(ADD, 8'd60, 8'd60, 1'b0, 1'b0);
        in_valid = 1'b0;
        n_checks++; if (out !== 8'd100) $display("FAIL mid_pre_out: got %0d want 100", out); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out !== 8'd0) $display("FAIL mid_rst_out: got %0d want 0", out); else n_pass++;
        n_checks++; if (carry_out !== 1'b0 || zero !== 1'b0)
            $display("FAIL mid_rst_flags: got carry=%b zero=%b want 0 0", carry_out, zero); else n_pass++;
        rst = 1'b0;
        out_ready = 1'b1;
        beat(ADD, 8'h77, 8'd9, 1'b1, 1'b0);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_flushed: got valid=%b want 0", out_valid); else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out !== 8'd9)
            $display("FAIL mid_acc_zero: got valid=%b out=%0d want valid=1 out=9", out_valid, out);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_logic();
        test_backpressure();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
